ifid_hazard_ctrl: RTL
=====================

# ifid_hazard_ctrl

Sequencing controller for the IF/ID pipeline register and the PC. Each cycle it decides whether the PC and IF/ID advance, hold, or take a NOP bubble. Its inputs are the instruction-memory handshake, the load-use hazard check between ID and EX, and branch/jump redirects resolved in EX. It also discards stale fetches after a redirect, detects fetch timeouts, and keeps a saturating stall counter.

## Interface
- WAIT_LIMIT, 8: consecutive not-ready fetch cycles tolerated before timeout (≥2).
- CNT_W, 16: width of stall_count.

- clk_IFID  in  1  clock, rising edge.
- rst_IFID  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request at current PC.
- imem_ready  in  1  fetch data valid this cycle.
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  source actually read.
- ex_rd  in  5  destination register of instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_redirect  in  1  taken branch/jump resolved in EX; PC mux selects target.
- pc_en  out  1  PC register load enable.
- en_IFID  out  1  IF/ID load enable.
- NOP_IFID  out  1  IF/ID NOP insert; has priority over en_IFID in IF/ID.
- nop_IDEX  out  1  bubble into ID/EX.
- imem_timeout  out  1  sticky fetch-timeout flag.
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0.

## Operation
- States: RUN, DISCARD, ERR. wait_cnt is a register sized to hold WAIT_LIMIT.
- hazard = ex_memread & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). It is masked to 0 outside RUN.
- Outputs are combinational from state and current inputs. Priority in RUN, first match wins:
  - ex_redirect: pc_en=1, en_IFID=0, NOP_IFID=1, nop_IDEX=1. Next state is RUN if imem_ready=1, otherwise DISCARD, because a stale fetch is outstanding.
  - hazard: pc_en=0, en_IFID=0, NOP_IFID=0, nop_IDEX=1. IF/ID holds and the fetch re-issues the same PC next cycle.
  - imem_ready=1: pc_en=1, en_IFID=1, NOP_IFID=0, nop_IDEX=0 (normal advance).
  - imem_ready=0: pc_en=0, en_IFID=0, NOP_IFID=1, nop_IDEX=0 (fetch bubble).
- DISCARD: imem_req=1, pc_en=0, en_IFID=0, NOP_IFID=1, nop_IDEX=0. ex_redirect is ignored. When imem_ready=1, the returned data is dropped and the next state is RUN, which then fetches the target.
- ERR: imem_req=0, pc_en=0, en_IFID=0, NOP_IFID=1, nop_IDEX=1. Only reset leaves ERR.
- imem_req=1 in RUN and DISCARD.
- wait_cnt:
  - Increments each cycle with imem_req=1 and imem_ready=0.
  - Clears on imem_ready=1 and on redirect.
  - If wait_cnt==WAIT_LIMIT-1 and imem_ready=0, next state is ERR and imem_timeout is set to 1.
- stall_count: +1 each cycle pc_en=0 outside reset, saturating at 2^CNT_W-1. It does not count during ERR.

## Timing
- Reset (async): state=RUN, wait_cnt=0, stall_count=0, imem_timeout=0.
- While rst_IFID=1, all outputs are forced low: imem_req, pc_en, en_IFID, NOP_IFID, nop_IDEX.
- Decisions are 0-cycle combinational and take effect at the next rising edge of clk_IFID.
- Load-use stall lasts exactly 1 cycle when imem_ready stays 1, because the load leaves EX.
- Redirect with ready fetch: 1 bubble in IF/ID and 1 in ID/EX. Target is fetched the cycle after.
- Redirect with pending fetch: DISCARD lasts until imem_ready plus 1 cycle; the target fetch is issued in RUN after that.
- Redirect coinciding with hazard: redirect wins; no hold.
- Timeout: ERR is entered at the edge after WAIT_LIMIT consecutive not-ready cycles.
- Reset asserted mid-DISCARD or in ERR returns the block to RUN with all counters cleared.

## Test plan
- Stream, imem_ready=1 always, no hazards, 10 cycles: pc_en=en_IFID=1 every cycle, NOP_IFID=nop_IDEX=0, stall_count=0.
- Load-use, ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle: that cycle pc_en=0, en_IFID=0, NOP_IFID=0, nop_IDEX=1; stall_count=1. Repeating with ex_rd=0 gives no stall.
- ex_redirect=1 with imem_ready=1: pc_en=1, NOP_IFID=1, nop_IDEX=1; state stays RUN; next cycle advances normally.
- imem_ready=0 for 3 cycles, ex_redirect=1 in cycle 1: DISCARD entered; NOP_IFID=1 and pc_en=0 until imem_ready=1 in cycle 4; then RUN; stall_count=3.
- WAIT_LIMIT=8, imem_ready held 0: after 8 cycles imem_timeout=1, state ERR, imem_req=0. It stays there until rst_IFID pulse, which clears all.
- CNT_W=4, 20 consecutive hazard cycles: stall_count saturates at 15.

Source files
------------

// File: rtl/ifid_hazard_ctrl.sv
// ============================================================================
// Module   : ifid_hazard_ctrl
// Purpose  : PC / IF-ID sequencing: advance, hold or bubble on fetch, load-use
//            and redirect events; stale-fetch discard, fetch timeout, stall count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifid_hazard_ctrl #(
    parameter int WAIT_LIMIT = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk_IFID,
    input  logic             rst_IFID,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             en_IFID,
    output logic             NOP_IFID,
    output logic             nop_IDEX,
    output logic             imem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int              WC_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DISCARD = 2'd1,
        S_ERR     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic               timeout_q, timeout_d;

    logic               hazard;
    logic               req_c, pc_en_c, en_c, nop_ifid_c, nop_idex_c;

    always_comb begin
        hazard = ex_memread && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
        stall_count_d = stall_count_q;
        req_c         = 1'b0;
        pc_en_c       = 1'b0;
        en_c          = 1'b0;
        nop_ifid_c    = 1'b0;
        nop_idex_c    = 1'b0;

        case (state_q)
            S_RUN: begin
                req_c = 1'b1;
                if (ex_redirect) begin
                    pc_en_c    = 1'b1;
                    nop_ifid_c = 1'b1;
                    nop_idex_c = 1'b1;
                    state_d    = imem_ready ? S_RUN : S_DISCARD;
                end else if (hazard) begin
                    nop_idex_c = 1'b1;
                end else if (imem_ready) begin
                    pc_en_c = 1'b1;
                    en_c    = 1'b1;
                end else begin
                    nop_ifid_c = 1'b1;
                end
            end
            S_DISCARD: begin
                req_c      = 1'b1;
                nop_ifid_c = 1'b1;
                if (imem_ready) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                nop_ifid_c = 1'b1;
                nop_idex_c = 1'b1;
            end
        endcase

        // A redirect restarts the fetch, so it also restarts the timeout window.
        if (imem_ready || ((state_q == S_RUN) && ex_redirect)) begin
            wait_cnt_d = '0;
        end else if (req_c) begin
            if (wait_cnt_q == WC_LAST) begin
                state_d   = S_ERR;
                timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end

        if (!pc_en_c && (state_q != S_ERR) && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_IFID or posedge rst_IFID) begin
        if (rst_IFID) begin
            state_q       <= S_RUN;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            timeout_q     <= timeout_d;
        end
    end

    // Control strobes are held low for the whole reset window.
    assign imem_req     = req_c      && !rst_IFID;
    assign pc_en        = pc_en_c    && !rst_IFID;
    assign en_IFID      = en_c       && !rst_IFID;
    assign NOP_IFID     = nop_ifid_c && !rst_IFID;
    assign nop_IDEX     = nop_idex_c && !rst_IFID;
    assign imem_timeout = timeout_q;
    assign stall_count  = stall_count_q;

endmodule

`default_nettype wire
